// File: rtl/json_feedback_receiver_if.sv
// Result channel of the JSON feedback receiver.
//
// Handshake: the master raises fb_valid together with fb_type/fb_left/fb_right
// and holds all four stable until a rising clock edge sees fb_valid && fb_ready.
// That edge completes the transfer; fb_valid drops after it unless a new result
// is loaded on the same edge. The slave may drive fb_ready at any time,
// independent of fb_valid.
//
// Signals:
//   fb_type  [15:0]  unsigned value of key "T"
//   fb_left  [15:0]  signed value of key "L"
//   fb_right [15:0]  signed value of key "R"
//   fb_valid         result held
//   fb_ready         consumer accepts result
interface json_feedback_receiver_if;
  logic [15:0] fb_type;
  logic [15:0] fb_left;
  logic [15:0] fb_right;
  logic        fb_valid;
  logic        fb_ready;

  modport master (output fb_type, output fb_left, output fb_right,
                  output fb_valid, input fb_ready);
  modport slave  (input fb_type, input fb_left, input fb_right,
                  input fb_valid, output fb_ready);
endinterface

// File: rtl/json_feedback_receiver.sv
// UART receiver plus streaming parser for motor-board feedback frames of the
// form {"T":1001,"L":120,"R":-45}. Each completed frame updates only the keys it
// carried and is offered on the fb interface.
//
// Optional feature: define JSON_RX_TIMEOUT_EN to abort a partial frame after
// 16 bit-times without a completed character.
//
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous active-low reset
//   uart_in          serial line, idle high, 8N1
//   fb               result channel (master side)
//   parse_error      one-cycle pulse on framing/syntax/length/timeout error
//   overrun          sticky: a completed frame was dropped
//   dbg_parser_state current parser state
//   dbg_rx_state     current UART receiver state
module json_feedback_receiver #(
  parameter int CLKS_PER_BIT = 434,
  parameter int BITS_N       = 8,
  parameter int MAX_BYTES    = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     uart_in,
  json_feedback_receiver_if.master fb,
  output logic                     parse_error,
  output logic                     overrun,
  output logic [2:0]               dbg_parser_state,
  output logic [1:0]               dbg_rx_state
);
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(BITS_N + 1);
  localparam int NW = $clog2(MAX_BYTES + 2);

  localparam logic [7:0] C_LBRACE = 8'h7B;
  localparam logic [7:0] C_RBRACE = 8'h7D;
  localparam logic [7:0] C_QUOTE  = 8'h22;
  localparam logic [7:0] C_COLON  = 8'h3A;
  localparam logic [7:0] C_COMMA  = 8'h2C;
  localparam logic [7:0] C_MINUS  = 8'h2D;
  localparam logic [7:0] C_SPACE  = 8'h20;

  // Synchronizer and edge history reset low: a line held low at reset release
  // then never looks like a 1->0 start edge.
  logic rx_meta, rx_sync, rx_prev;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b0;
      rx_sync <= 1'b0;
      rx_prev <= 1'b0;
    end else begin
      rx_meta <= uart_in;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // ---------------- UART receiver ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  rx_state_t         rx_state, rx_state_n;
  logic [CW-1:0]     rx_cnt;
  logic [BW-1:0]     rx_bit;
  logic [BITS_N-1:0] rx_shift;
  logic              rx_byte_valid, rx_frame_err;
  logic              half_hit, bit_hit, last_bit;

  assign half_hit = (rx_cnt == CW'(HALF_BIT));
  assign bit_hit  = (rx_cnt == CW'(CLKS_PER_BIT - 1));
  assign last_bit = (rx_bit == BW'(BITS_N - 1));

  always_comb begin
    rx_state_n = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_sync) rx_state_n = RX_START;
      RX_START: if (half_hit) rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_hit && last_bit) rx_state_n = RX_STOP;
      RX_STOP:  if (bit_hit) rx_state_n = RX_IDLE;
      default:  rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state      <= RX_IDLE;
      rx_cnt        <= '0;
      rx_bit        <= '0;
      rx_shift      <= '0;
      rx_byte_valid <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_state      <= rx_state_n;
      rx_byte_valid <= 1'b0;
      rx_frame_err  <= 1'b0;
      // The counter restarts on every state change and every full bit, so
      // after the half-bit start check each bit_hit lands at mid-bit.
      if (rx_state == RX_IDLE || rx_state_n != rx_state || bit_hit) rx_cnt <= '0;
      else rx_cnt <= rx_cnt + 1'b1;
      if (rx_state == RX_START) rx_bit <= '0;
      if (rx_state == RX_DATA && bit_hit) begin
        rx_shift <= {rx_sync, rx_shift[BITS_N-1:1]};
        rx_bit   <= rx_bit + 1'b1;
      end
      if (rx_state == RX_STOP && bit_hit) begin
        rx_byte_valid <= rx_sync;
        rx_frame_err  <= !rx_sync;
      end
    end
  end

  // ---------------- Parser ----------------
  typedef enum logic [2:0] {IDLE, KEY_OPEN, KEY_CHAR, KEY_CLOSE, COLON, VALUE, SEP} p_state_t;
  p_state_t      p_state, p_state_n;
  logic [7:0]    ch, key, key_n;
  logic [14:0]   acc, acc_n;      // magnitude, saturates at 32767
  logic          neg, neg_n;
  logic [2:0]    ndig, ndig_n;
  logic [NW-1:0] bcnt, bcnt_n;
  logic [2:0]    seen, seen_n;    // {R, L, T} seen in this frame
  logic [15:0]   st_t, st_l, st_r, st_t_n, st_l_n, st_r_n;
  logic          err_n, done_n, fail, sep_char, ignore, is_digit, timeout_hit;
  logic [19:0]   acc_next;
  logic [15:0]   value;

  assign ch       = 8'(rx_shift);
  assign is_digit = (ch >= 8'h30) && (ch <= 8'h39);
  assign acc_next = 20'(acc) * 20'd10 + 20'(ch[3:0]);
  assign value    = neg ? (16'd0 - {1'b0, acc}) : {1'b0, acc};
  // Space is skipped everywhere except after a digit, where it ends the number.
  assign ignore   = (ch == C_SPACE) && !(p_state == VALUE && ndig != 3'd0);

`ifdef JSON_RX_TIMEOUT_EN
  localparam int TO_LIMIT = 16 * CLKS_PER_BIT;
  localparam int TW = $clog2(TO_LIMIT + 1);
  logic [TW-1:0] to_cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) to_cnt <= '0;
    else if (p_state == IDLE || rx_byte_valid || rx_frame_err) to_cnt <= '0;
    else to_cnt <= to_cnt + 1'b1;
  end
  assign timeout_hit = (to_cnt == TW'(TO_LIMIT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    p_state_n = p_state;
    key_n     = key;
    acc_n     = acc;
    neg_n     = neg;
    ndig_n    = ndig;
    bcnt_n    = bcnt;
    seen_n    = seen;
    st_t_n    = st_t;
    st_l_n    = st_l;
    st_r_n    = st_r;
    err_n     = 1'b0;
    done_n    = 1'b0;
    fail      = 1'b0;
    sep_char  = 1'b0;
    if (rx_frame_err || timeout_hit) begin
      err_n     = 1'b1;
      p_state_n = IDLE;
    end else if (rx_byte_valid) begin
      if (ch == C_LBRACE) begin
        // Opening brace always restarts a frame, silently abandoning any partial one.
        p_state_n = KEY_OPEN;
        bcnt_n    = NW'(1);
        seen_n    = '0;
      end else if (p_state != IDLE) begin
        if (bcnt == NW'(MAX_BYTES)) begin
          fail = 1'b1;
        end else begin
          bcnt_n = bcnt + 1'b1;
          if (!ignore) begin
            case (p_state)
              KEY_OPEN:  if (ch == C_QUOTE) p_state_n = KEY_CHAR; else fail = 1'b1;
              KEY_CHAR:  begin key_n = ch; p_state_n = KEY_CLOSE; end
              KEY_CLOSE: if (ch == C_QUOTE) p_state_n = COLON; else fail = 1'b1;
              COLON: begin
                if (ch == C_COLON) begin
                  p_state_n = VALUE;
                  acc_n     = '0;
                  neg_n     = 1'b0;
                  ndig_n    = '0;
                end else fail = 1'b1;
              end
              VALUE: begin
                if (is_digit) begin
                  if (ndig == 3'd5) fail = 1'b1;
                  else begin
                    acc_n  = (acc_next > 20'd32767) ? 15'h7FFF : acc_next[14:0];
                    ndig_n = ndig + 3'd1;
                  end
                end else if (ndig == 3'd0) begin
                  if (ch == C_MINUS && !neg) neg_n = 1'b1;
                  else fail = 1'b1;
                end else begin
                  // Number finished: store it, then treat this char as the separator.
                  sep_char = 1'b1;
                  case (key)
                    8'h54:   begin st_t_n = value; seen_n[0] = 1'b1; end
                    8'h4C:   begin st_l_n = value; seen_n[1] = 1'b1; end
                    8'h52:   begin st_r_n = value; seen_n[2] = 1'b1; end
                    default: ;
                  endcase
                end
              end
              SEP:     sep_char = 1'b1;
              default: fail = 1'b1;
            endcase
            if (sep_char) begin
              case (ch)
                C_COMMA:  p_state_n = KEY_OPEN;
                C_RBRACE: begin done_n = 1'b1; p_state_n = IDLE; end
                C_SPACE:  p_state_n = SEP;
                default:  fail = 1'b1;
              endcase
            end
          end
        end
      end
      if (fail) begin
        err_n     = 1'b1;
        done_n    = 1'b0;
        p_state_n = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_state <= IDLE;
      key     <= '0;
      acc     <= '0;
      neg     <= 1'b0;
      ndig    <= '0;
      bcnt    <= '0;
      seen    <= '0;
      st_t    <= '0;
      st_l    <= '0;
      st_r    <= '0;
    end else begin
      p_state <= p_state_n;
      key     <= key_n;
      acc     <= acc_n;
      neg     <= neg_n;
      ndig    <= ndig_n;
      bcnt    <= bcnt_n;
      seen    <= seen_n;
      st_t    <= st_t_n;
      st_l    <= st_l_n;
      st_r    <= st_r_n;
    end
  end

  // Result holding register: a frame finishing while the previous result is
  // still unaccepted is dropped; accept and finish on one edge loads the new one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fb.fb_type  <= '0;
      fb.fb_left  <= '0;
      fb.fb_right <= '0;
      fb.fb_valid <= 1'b0;
      parse_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      parse_error <= err_n;
      if (done_n) begin
        if (fb.fb_valid && !fb.fb_ready) begin
          overrun <= 1'b1;
        end else begin
          fb.fb_valid <= 1'b1;
          if (seen_n[0]) fb.fb_type  <= st_t_n;
          if (seen_n[1]) fb.fb_left  <= st_l_n;
          if (seen_n[2]) fb.fb_right <= st_r_n;
        end
      end else if (fb.fb_valid && fb.fb_ready) begin
        fb.fb_valid <= 1'b0;
      end
    end
  end

  assign dbg_parser_state = p_state;
  assign dbg_rx_state     = rx_state;
endmodule

// File: tb/tb_json_feedback_receiver.sv
// Directed bench for json_feedback_receiver: drives UART characters, keeps the
// expected fb_type/fb_left/fb_right triple per frame in a queue and compares
// each offered result against it.
module tb_json_feedback_receiver;
  localparam int CPB        = 16;
  localparam int WAIT_LIMIT = 40 * CPB;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       uart_in;
  logic       parse_error;
  logic       overrun;
  logic [2:0] dbg_parser_state;
  logic [1:0] dbg_rx_state;

  json_feedback_receiver_if fb_if ();

  json_feedback_receiver #(
    .CLKS_PER_BIT(CPB),
    .BITS_N(8),
    .MAX_BYTES(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .uart_in(uart_in),
    .fb(fb_if),
    .parse_error(parse_error),
    .overrun(overrun),
    .dbg_parser_state(dbg_parser_state),
    .dbg_rx_state(dbg_rx_state)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          total = 0;
  int          bad = 0;
  int          perr_cnt = 0;
  int          perr_base = 0;
  bit          summary_done = 1'b0;
  logic [47:0] exp_q[$];
  logic [15:0] exp_t = 16'd0;
  logic [15:0] exp_l = 16'd0;
  logic [15:0] exp_r = 16'd0;

  // Counts cycles with parse_error high; a clean pulse adds exactly one.
  always @(posedge clk) begin
    if (parse_error === 1'b1) perr_cnt <= perr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_bit(input logic b);
    uart_in = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_v);
    uart_in = 1'b1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic expect_frame();
    exp_q.push_back({exp_t, exp_l, exp_r});
  endtask

  task automatic check_result(input string tag);
    logic [47:0] e;
    int n = 0;
    while (fb_if.fb_valid !== 1'b1 && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 16'(fb_if.fb_valid), 16'd1);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s_queue: observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_type"},  fb_if.fb_type,  e[47:32]);
      chk({tag, "_left"},  fb_if.fb_left,  e[31:16]);
      chk({tag, "_right"}, fb_if.fb_right, e[15:0]);
    end
  endtask

  task automatic accept(input string tag);
    fb_if.fb_ready = 1'b1;
    @(negedge clk);
    fb_if.fb_ready = 1'b0;
    chk({tag, "_clr"}, 16'(fb_if.fb_valid), 16'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    string pad;
    rst = 1'b0;
    uart_in = 1'b1;
    fb_if.fb_ready = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_type",  fb_if.fb_type, 16'd0);
    chk("rst_left",  fb_if.fb_left, 16'd0);
    chk("rst_right", fb_if.fb_right, 16'd0);
    chk("rst_valid", 16'(fb_if.fb_valid), 16'd0);
    chk("rst_perr",  16'(parse_error), 16'd0);
    chk("rst_ovr",   16'(overrun), 16'd0);
    rst = 1'b1;
    repeat (2 * CPB) @(negedge clk);

    // Full frame with all three keys, negative right value.
    perr_base = perr_cnt;
    exp_t = 16'd1001; exp_l = 16'd120; exp_r = 16'hFFD3;
    expect_frame();
    send_str("{\"T\":1001,\"L\":120,\"R\":-45}");
    check_result("f1");
    chk("f1_perr", 16'(perr_cnt - perr_base), 16'd0);
    accept("f1");

    // Saturation of a five-digit value; other keys untouched.
    exp_l = 16'd32767;
    expect_frame();
    send_str("{\"L\":99999}");
    check_result("sat");
    accept("sat");

    // Six digits is an error; no result.
    perr_base = perr_cnt;
    send_str("{\"L\":123456}");
    repeat (CPB) @(negedge clk);
    chk("six_perr", 16'(perr_cnt - perr_base), 16'd1);
    chk("six_valid", 16'(fb_if.fb_valid), 16'd0);

    // Overrun: second frame dropped while first is unaccepted.
    exp_t = 16'd1;
    expect_frame();
    send_str("{\"T\":1}");
    check_result("ov1");
    chk("ov_before", 16'(overrun), 16'd0);
    send_str("{\"T\":2}");
    repeat (CPB) @(negedge clk);
    chk("ov_keep_type", fb_if.fb_type, exp_t);
    chk("ov_flag", 16'(overrun), 16'd1);
    chk("ov_valid", 16'(fb_if.fb_valid), 16'd1);
    accept("ov1");
    exp_t = 16'd3;
    expect_frame();
    send_str("{\"T\":3}");
    check_result("ov3");
    chk("ov_sticky", 16'(overrun), 16'd1);
    accept("ov3");

    // Brace with a low stop bit is discarded with an error.
    perr_base = perr_cnt;
    send_byte(8'h7B, 1'b0);
    drive_bit(1'b1);
    chk("stop_perr", 16'(perr_cnt - perr_base), 16'd1);
    exp_t = 16'd5;
    expect_frame();
    send_str("{\"T\":5}");
    check_result("stop_next");
    accept("stop_next");

    // Brace mid-frame restarts silently; only R reported.
    perr_base = perr_cnt;
    exp_r = 16'hFFFD;
    expect_frame();
    send_str("{\"T\":7");
    send_str("{\"R\":-3}");
    check_result("abort");
    chk("abort_perr", 16'(perr_cnt - perr_base), 16'd0);
    accept("abort");

    // Length boundary: 64 characters accepted, 65 rejected.
    pad = "";
    for (int i = 0; i < 57; i++) pad = {pad, " "};
    exp_t = 16'd9;
    expect_frame();
    send_str({"{", pad, "\"T\":9}"});
    check_result("len64");
    accept("len64");
    perr_base = perr_cnt;
    send_str({"{", pad, " \"T\":8}"});
    repeat (CPB) @(negedge clk);
    chk("len65_perr", 16'(perr_cnt - perr_base), 16'd1);
    chk("len65_valid", 16'(fb_if.fb_valid), 16'd0);

    // Partial frame followed by a long idle gap.
    perr_base = perr_cnt;
    send_str("{\"T\":1");
    repeat (20 * CPB) @(negedge clk);
`ifdef JSON_RX_TIMEOUT_EN
    chk("to_perr", 16'(perr_cnt - perr_base), 16'd1);
    chk("to_valid", 16'(fb_if.fb_valid), 16'd0);
`else
    chk("to_perr", 16'(perr_cnt - perr_base), 16'd0);
    chk("to_valid", 16'(fb_if.fb_valid), 16'd0);
    exp_t = 16'd1;
    expect_frame();
    send_str("}");
    check_result("to_late");
    accept("to_late");
`endif

    // Reset in the middle of a character clears everything.
    uart_in = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_type",  fb_if.fb_type, 16'd0);
    chk("mid_rst_left",  fb_if.fb_left, 16'd0);
    chk("mid_rst_right", fb_if.fb_right, 16'd0);
    chk("mid_rst_valid", 16'(fb_if.fb_valid), 16'd0);
    chk("mid_rst_perr",  16'(parse_error), 16'd0);
    chk("mid_rst_ovr",   16'(overrun), 16'd0);
    uart_in = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    rst = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    perr_base = perr_cnt;
    exp_t = 16'd5; exp_l = 16'd0; exp_r = 16'd0;
    expect_frame();
    send_str("{\"T\":5}");
    check_result("post_rst");
    chk("post_rst_perr", 16'(perr_cnt - perr_base), 16'd0);
    accept("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    summary_done = 1'b1;
    $finish;
  end

  // Guarantees the summary appears even if the simulator halts on an error.
  final begin
    if (!summary_done) $display("test done: total=%0d bad=%0d", total, bad);
  end
endmodule

// File: doc/json_feedback_receiver.md
JSON_FEEDBACK_RECEIVER -- requirements
Module: json_feedback_receiver

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434 (50_000_000/115_200), clock cycles per UART bit.
REQ-002 SHALL have parameter BITS_N, default 8, UART data bits per character.
REQ-003 SHALL have parameter MAX_BYTES, default 64, maximum characters per frame including braces.
REQ-004 SHALL have ports: clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port: uart_in  input  1  serial line from motor board, idle high, 8N1.
REQ-007 SHALL have ports: fb_type  output  16  unsigned value of key "T"; fb_left  output  16  signed value of key "L"; fb_right  output  16  signed value of key "R".
REQ-008 SHALL have ports: fb_valid  output  1  frame result held; fb_ready  input  1  consumer accepts result.
REQ-009 SHALL have ports: parse_error  output  1  one-cycle error pulse; overrun  output  1  sticky dropped-frame flag.

Function
REQ-010 SHALL pass uart_in through a 2-flop synchronizer before any use.
REQ-011 UART RX SHALL detect a falling edge, re-check low at CLKS_PER_BIT/2, sample each data bit at mid-bit (LSB first), and sample the stop bit at mid-bit.
REQ-012 A low stop bit SHALL discard the character, pulse parse_error, and return the parser to IDLE.
REQ-013 Parser FSM states SHALL be IDLE, KEY_OPEN, KEY_CHAR, KEY_CLOSE, COLON, VALUE, SEP.
REQ-014 IDLE SHALL ignore all characters except '{', which resets the frame byte count and clears the per-frame seen flags; the parser then enters KEY_OPEN.
REQ-015 KEY_OPEN expects '"'; KEY_CHAR latches any one character as the key; KEY_CLOSE expects '"'; COLON expects ':'.
REQ-016 VALUE SHALL accept one optional leading '-' followed by 1-5 digits, computing acc = acc*10 + digit and saturating magnitude at 32767.
REQ-017 The first non-digit after at least one digit SHALL end VALUE and be processed as the SEP character in the same character slot.
REQ-018 In SEP, ',' SHALL go to KEY_OPEN and '}' SHALL complete the frame; keys other than T/L/R SHALL be parsed and discarded.
REQ-019 Space (0x20) SHALL be ignored in every state except inside a digit run, where it ends the value.
REQ-020 Any unexpected character, a sixth digit, '-' without a digit, or byte count > MAX_BYTES SHALL pulse parse_error for one cycle and return the parser to IDLE.
REQ-021 '{' received in any non-IDLE state SHALL abort the current frame without an error pulse and restart at KEY_OPEN.
REQ-022 On frame completion, outputs SHALL update only for keys seen in that frame, and fb_valid SHALL assert one cycle after the '}' stop-bit sample.
REQ-023 fb_valid SHALL stay high until a cycle with fb_valid && fb_ready, then deassert on the next edge.
REQ-024 A frame completing while fb_valid is high and not accepted in that cycle SHALL be dropped and SHALL set overrun, which stays set until reset.
REQ-025 Acceptance and completion in the same cycle SHALL load the new frame, keep fb_valid high, and leave overrun unchanged.

Reset
REQ-026 While rst is low: fb_type = 0, fb_left = 0, fb_right = 0, fb_valid = 0, parse_error = 0, overrun = 0, parser in IDLE, RX idle.
REQ-027 Reset mid-character or mid-frame SHALL discard all partial data; after release, reception resumes only at the next falling edge.

Configuration
REQ-028 Macro JSON_RX_TIMEOUT_EN SHALL control the inter-character timeout.
REQ-029 With JSON_RX_TIMEOUT_EN defined: in any non-IDLE state, 16*CLKS_PER_BIT cycles with no completed character SHALL pulse parse_error and return the parser to IDLE.
REQ-030 Without JSON_RX_TIMEOUT_EN: no timeout; a partial frame waits indefinitely.

Verification
REQ-031 Send {"T":1001,"L":120,"R":-45} -> fb_valid=1, fb_type=1001, fb_left=120, fb_right=0xFFD3 (-45); fb_ready=1 for 1 cycle -> fb_valid=0.
REQ-032 Send {"L":99999} -> fb_left=32767 after saturation, fb_type/fb_right unchanged; {"L":123456} -> parse_error pulse, no fb_valid.
REQ-033 Send two frames, T=1 then T=2, with fb_ready held 0 -> fb_type stays 1, overrun=1; assert fb_ready, then a third frame T=3 -> fb_type=3.
REQ-034 Character 0x7B with stop bit driven low -> parse_error pulse; next valid frame {"T":5} parses with fb_type=5.
REQ-035 Send {"T":7 then {"R":-3} -> only fb_right=-3 reported, no parse_error; assert rst low mid-character -> all outputs 0.
REQ-036 With JSON_RX_TIMEOUT_EN: send {"T":1 then idle 20 bit-times -> parse_error pulse, no fb_valid; without the macro: no pulse, and appending } later yields fb_type=1.
